// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small first-word-fall-through byte FIFO and sticky errors.
// Define UART_RX_PARITY_EN for 8E1 framing with a PARITY state and a sticky parity_err output.
module uart_rx #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          ren,
   output logic [7:0]                    rdata,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
`ifdef UART_RX_PARITY_EN
   ,
   output logic                          parity_err
`endif
);

   localparam int CPB   = CLK_HZ / BAUD;
   localparam int CNT_W = $clog2(CPB);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
   localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   state_t           state, state_n;
   logic [1:0]       sync;
   logic             rxs;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             push, frame_set;
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic [7:0]       mem [FIFO_DEPTH];
   logic             full, do_pop, do_push, overrun_set;
`ifdef UART_RX_PARITY_EN
   logic             par_bad, par_bad_n, parity_set;
`endif

   assign rxs = sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= 2'b11;
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sync  <= {sync[0], rx};
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_n;
`endif
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      shreg_n   = shreg;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n  = par_bad;
      parity_set = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
            if (!rxs) state_n = START;
         end
         START: if (cnt == CNT_HALF) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = rxs ? IDLE : DATA;
         end
         DATA: if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            shreg_n = {rxs, shreg[7:1]};
            idx_n   = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state_n = PARITY;
`else
            if (idx == 3'd7) state_n = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (cnt == CNT_LAST) begin
            cnt_n      = '0;
            par_bad_n  = ^{shreg, rxs};
            parity_set = ^{shreg, rxs};
            state_n    = STOP;
         end
`endif
         STOP: if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
               push = !par_bad;
`else
               push = 1'b1;
`endif
               state_n = IDLE;
            end else begin
               frame_set = 1'b1;
               state_n   = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            cnt_n = '0;
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the head is popped in the same cycle.
   assign count       = wr_ptr - rd_ptr;
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_V);
   assign do_pop      = ren && !empty;
   assign do_push     = push && (!full || do_pop);
   assign overrun_set = push && full && !do_pop;
   assign rdata       = empty ? 8'h00 : mem[rd_ptr[PTR_W-1:0]];

   // NOTE: storage is deliberately not reset; rdata is masked while empty so stale entries never show.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (frame_set)        frame_err <= 1'b1;
         else if (err_clr)     frame_err <= 1'b0;
         if (overrun_set)      overrun <= 1'b1;
         else if (err_clr)     overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (parity_set)       parity_err <= 1'b1;
         else if (err_clr)     parity_err <= 1'b0;
`endif
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Single-clock UART receiver: 8N1 serial line in, bytes out through a small first-word-fall-through FIFO.
- Complements the existing transmit-only UART path, so the CPU can receive host bytes.
- Sits beside the PS/2 receiver and is read by the memory-mapped I/O logic with the same ren-pop style as the keyboard.
- Sticky error flags report framing and overrun faults.

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz.
- BAUD, 115200, line bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer divide) must be ≥ 4.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- ren  input  1  pop the FIFO head this cycle.
- rdata  output  8  FIFO head byte; valid when empty=0.
- empty  output  1  FIFO has no entries.
- count  output  $clog2(FIFO_DEPTH)+1  number of entries held.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte arrived while the FIFO was full.
- err_clr  input  1  clear both sticky flags.

Behaviour:
- Reset is synchronous and active-high, and takes effect anywhere, including mid-frame. Reset values:
  - rx synchronizer flops = 1.
  - state = IDLE; bit counter and bit index = 0.
  - FIFO pointers = 0, so empty=1 and count=0.
  - rdata = 0, frame_err = 0, overrun = 0.
  - Any partial frame is discarded.
- rx passes through a 2-flop synchronizer. Only the synced value (rxs) is used.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE, plus PARITY under the optional feature.
  - IDLE: rxs=0 → START, cnt=0.
  - START: cnt counts to CLKS_PER_BIT/2-1. At terminal count, rxs=0 → DATA with cnt=0 and idx=0. rxs=1 is a glitch → IDLE.
  - DATA: at cnt=CLKS_PER_BIT-1, shift rxs into the byte LSB-first, cnt=0, idx++. After the 8th bit → STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rxs.
    - rxs=1 → push the byte, go to IDLE.
    - rxs=0 → set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then → IDLE. This stops a break condition from producing bytes.
- Data sampling falls at mid-bit, one bit period after the mid-start sample.
- Push timing: the byte is written on the cycle of the stop-bit sample. rdata, empty=0 and count update the following cycle.
- FIFO is first-word-fall-through: rdata shows the head combinationally from storage.
- ren with empty=1 is ignored: no pointer change, no error.
- Push when full with no pop in the same cycle: the new byte is dropped, overrun is set, and existing contents are kept.
- Push and pop in the same cycle while full: both occur, count is unchanged, overrun is not set.
- Push and pop in the same cycle while empty: the push occurs, and the pop is ignored because empty=1 at that cycle.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- err_clr clears frame_err and overrun. If a set event and err_clr occur in the same cycle, the set wins.
- Error events never stall the receiver.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame format is 8E1.
  - A PARITY state is inserted between DATA and STOP and samples one bit at mid-bit.
  - Adds an output parity_err (1 bit, sticky, reset 0, cleared by err_clr, set wins).
  - parity_err is set if XOR(data bits, parity bit) ≠ 0.
  - A byte with bad parity is discarded even when its stop bit is good.
- When not defined:
  - Frame format is 8N1.
  - There is no PARITY state and no parity_err port.

Test Plan:
- Common bench setup: CLK_HZ=16, BAUD=1 (16 clks/bit), FIFO_DEPTH=4.
- Reset, then send 0x65 → empty deasserts, rdata=0x65, count=1, both error flags 0.
- Idle line, then pull rx low for 5 clocks → no byte pushed, state returns to IDLE, empty stays 1.
- Send 0xA5 with the stop bit held low for 3 bit times → frame_err=1, count=0. A following 0x3C is received correctly once the line returns high. err_clr clears frame_err.
- Send 0x01,0x02,0x03,0x04,0x05 with no ren → count=4 and overrun=1. Popping returns 0x01–0x04 in order, then empty=1.
- With the FIFO full, assert ren on the exact cycle 0x77 is pushed → overrun stays 0, count stays 4, and the last entry read is 0x77.
- Assert reset mid-DATA of 0xFF, then send 0x5A → only 0x5A appears. With UART_RX_PARITY_EN, 0x5A with odd parity bit 1 sets parity_err=1 and count=0.
